// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execute controller: instruction fields, ALU opcodes, PSR layout, FSM states.
// ALU_EXEC_CTRL_ILLEGAL_TRAP_EN adds the HALT state used by the illegal-instruction trap.
package alu_pkg;

  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;

  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_ADDU  = 4'b0110;
  localparam logic [3:0] EXT_ADDC  = 4'b0111;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_CMPU  = 4'b1111;
  localparam logic [3:0] EXT_LSHI0 = 4'b0000;
  localparam logic [3:0] EXT_LSHI1 = 4'b0001;
  localparam logic [3:0] EXT_LSH   = 4'b0100;

  localparam logic [7:0] ALU_OP_SUB  = 8'h09;
  localparam logic [7:0] ALU_OP_CMP  = 8'h0B;
  localparam logic [7:0] ALU_OP_LSHI = 8'h80;
  localparam logic [7:0] ALU_OP_LSH  = 8'h84;

  localparam int unsigned PSR_Z = 4;
  localparam int unsigned PSR_C = 3;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_N = 1;
  localparam int unsigned PSR_L = 0;

  localparam logic [1:0] BSEL_REG  = 2'd0;
  localparam logic [1:0] BSEL_IMM8 = 2'd1;
  localparam logic [1:0] BSEL_IMM4 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
    ST_HALT,
`endif
    ST_WB
  } state_e;

  function automatic logic is_nop_ext(input logic [3:0] ext);
    return ext inside {4'b0000, 4'b1010, [4'b1100:4'b1110]};
  endfunction

endpackage

// File: rtl/alu_exec_decode.sv
// Combinational instruction decode: maps op_hi/op_ext onto the ALU opcode, B-operand source
// and the writeback/PSR side effects.
module alu_exec_decode
  import alu_pkg::*;
(
  input  logic [3:0] op_hi_i,
  input  logic [3:0] op_ext_i,
  output logic [7:0] alu_opcode_o,
  output logic [1:0] imm_sel_o,
  output logic       sign_ext_o,
  output logic       writes_rf_o,
  output logic       updates_psr_o,
  output logic       illegal_o
);

  always_comb begin
    alu_opcode_o  = {op_hi_i, op_ext_i};
    imm_sel_o     = BSEL_REG;
    sign_ext_o    = 1'b0;
    writes_rf_o   = 1'b1;
    updates_psr_o = 1'b1;
    illegal_o     = 1'b0;

    case (op_hi_i)
      OP_REG: begin
        if (is_nop_ext(op_ext_i)) begin
          writes_rf_o   = 1'b0;
          updates_psr_o = 1'b0;
        end else if (op_ext_i == EXT_CMP || op_ext_i == EXT_CMPU) begin
          writes_rf_o = 1'b0;
        end
      end
      OP_ADDI, OP_ADDCI: begin
        imm_sel_o  = BSEL_IMM8;
        sign_ext_o = 1'b1;
      end
      OP_ADDUI: imm_sel_o = BSEL_IMM8;
      OP_SUBI: begin
        alu_opcode_o = ALU_OP_SUB;
        imm_sel_o    = BSEL_IMM8;
        sign_ext_o   = 1'b1;
      end
      OP_CMPI: begin
        alu_opcode_o = ALU_OP_CMP;
        imm_sel_o    = BSEL_IMM8;
        sign_ext_o   = 1'b1;
        writes_rf_o  = 1'b0;
      end
      OP_SHIFT: begin
        if (op_ext_i == EXT_LSHI0 || op_ext_i == EXT_LSHI1) begin
          alu_opcode_o = ALU_OP_LSHI;
          imm_sel_o    = BSEL_IMM4;
        end else if (op_ext_i == EXT_LSH) begin
          alu_opcode_o = ALU_OP_LSH;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase

    if (illegal_o) begin
      alu_opcode_o  = '0;
      writes_rf_o   = 1'b0;
      updates_psr_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Four-cycle decode/execute sequencer in front of the 16-bit ALU; owns the PSR.
// ALU_EXEC_CTRL_ILLEGAL_TRAP_EN: illegal instructions halt the controller until reset.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [7:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] psr,
  output logic              busy,
  output logic              illegal
);

  state_e              state_q;
  logic [15:0]         instr_q;
  logic [7:0]          alu_opcode_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [DATA_W-1:0]   alu_b_d;
  logic                alu_cin_q;
  logic                rf_we_q;
  logic [FLAG_W-1:0]   psr_q;

  logic [7:0]          dec_opcode;
  logic [1:0]          dec_imm_sel;
  logic                dec_sign_ext;
  logic                dec_writes_rf;
  logic                dec_updates_psr;
  logic                dec_illegal;

  alu_exec_decode u_decode (
    .op_hi_i       (instr_q[15:12]),
    .op_ext_i      (instr_q[7:4]),
    .alu_opcode_o  (dec_opcode),
    .imm_sel_o     (dec_imm_sel),
    .sign_ext_o    (dec_sign_ext),
    .writes_rf_o   (dec_writes_rf),
    .updates_psr_o (dec_updates_psr),
    .illegal_o     (dec_illegal)
  );

  always_comb begin
    alu_b_d = rf_rdata_b;
    case (dec_imm_sel)
      BSEL_IMM8: alu_b_d = dec_sign_ext ? {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]}
                                        : {{(DATA_W-8){1'b0}}, instr_q[7:0]};
      BSEL_IMM4: alu_b_d = {{(DATA_W-4){1'b0}}, instr_q[3:0]};
      default:   ;
    endcase
  end

`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      psr_q        <= '0;
`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: state_q <= ST_EXEC;
        ST_EXEC: begin
          alu_a_q      <= rf_rdata_a;
          alu_b_q      <= alu_b_d;
          alu_opcode_q <= dec_opcode;
          alu_cin_q    <= psr_q[PSR_C];
          // Write enable is registered here so it is already high for the whole WB cycle.
          rf_we_q      <= dec_writes_rf;
`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= ST_HALT;
          end else begin
            state_q   <= ST_WB;
          end
`else
          state_q      <= ST_WB;
`endif
        end
        ST_WB: begin
          rf_we_q <= 1'b0;
          if (dec_updates_psr && !dec_illegal) psr_q <= alu_flags;
          state_q <= ST_IDLE;
        end
`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
        ST_HALT: state_q <= ST_HALT;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rf_raddr_a  = instr_q[11:8];
  assign rf_raddr_b  = instr_q[3:0];
  assign rf_we       = rf_we_q;
  assign rf_waddr    = instr_q[11:8];
  assign rf_wdata    = alu_c;
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = alu_cin_q;
  assign psr         = psr_q;
`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
  assign illegal     = illegal_q;
`else
  assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: provides a synchronous-read register file and a behavioural ALU,
// runs directed vectors, hand sequences and randomized instructions against a reference model.
module tb_alu_exec_ctrl;

`ifdef ALU_EXEC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_c;
  logic        alu_cin;
  logic [4:0]  alu_flags, psr;
  logic        busy, illegal;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(16), .REG_AW(4), .FLAG_W(5)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_c(alu_c),
    .alu_flags(alu_flags), .psr(psr), .busy(busy), .illegal(illegal)
  );

  // Register file: synchronous read, bench-side pokes go through the same process.
  logic [15:0] rf [16];
  logic [15:0] rd_a_q, rd_b_q;
  logic        poke_en = 1'b0;
  logic [3:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;
  int unsigned we_cnt = 0;

  always @(posedge clk) begin
    rd_a_q <= rf[rf_raddr_a];
    rd_b_q <= rf[rf_raddr_b];
    if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (poke_en) rf[poke_addr] <= poke_data;
  end
  assign rf_rdata_a = rd_a_q;
  assign rf_rdata_b = rd_b_q;

  // ALU: flags {Z,C,F,N,L}; 5x/6x/7x opcodes behave as ADD/ADDU/ADDC, 8x as left shift.
  function automatic logic [20:0] alu_f(input logic [7:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [3:0]  k;
    logic [16:0] s;
    logic [15:0] r;
    logic        z, c, f, n, l;
    k = (op[7:4] == 4'h0) ? op[3:0] : op[7:4];
    r = '0; c = 1'b0; f = 1'b0; n = 1'b0; l = 1'b0; s = '0;
    if (op[7:4] == 4'h8) r = a << b[3:0];
    else begin
      case (k)
        4'h1: r = a & b;
        4'h2: r = a | b;
        4'h3: r = a ^ b;
        4'h4: r = ~a;
        4'h5, 4'h6, 4'h7: begin
          s = {1'b0, a} + {1'b0, b} + ((k == 4'h7) ? 17'(cin) : 17'd0);
          r = s[15:0]; c = s[16];
          f = (a[15] == b[15]) && (r[15] != a[15]);
        end
        4'h8: r = b;
        4'h9: begin
          s = {1'b0, a} - {1'b0, b};
          r = s[15:0]; c = s[16];
          f = (a[15] != b[15]) && (r[15] != a[15]);
        end
        4'hB: begin n = $signed(a) < $signed(b); l = a < b; end
        4'hF: l = a < b;
        default: r = '0;
      endcase
    end
    z = (k == 4'hB || k == 4'hF) ? (a == b) : (r == 16'h0000);
    return {z, c, f, n, l, r};
  endfunction

  always_comb {alu_flags, alu_c} = alu_f(alu_opcode, alu_a, alu_b, alu_cin);

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Observations from one instruction, all taken at negedges after the accept edge.
  logic        o_busy, o_rdy_mid, o_early, o_we, o_cin, o_rdy, o_ill;
  logic [3:0]  o_waddr;
  logic [15:0] o_a, o_b;
  logic [7:0]  o_op;
  logic [4:0]  o_psr;

  task automatic do_instr(input logic [15:0] ins);
    int unsigned w = 0;
    @(negedge clk);
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    // Offer another instruction while busy; it must be ignored.
    instr = 16'h0162;
    o_busy = busy; o_rdy_mid = instr_ready; o_early = rf_we;
    @(negedge clk);
    o_early = o_early | rf_we;
    @(negedge clk);
    instr_valid = 1'b0;
    o_we = rf_we; o_waddr = rf_waddr; o_op = alu_opcode;
    o_a = alu_a; o_b = alu_b; o_cin = alu_cin;
    @(negedge clk);
    o_psr = psr; o_rdy = instr_ready; o_ill = illegal;
  endtask

  task automatic ref_model(input logic [15:0] ins, input logic [15:0] va, input logic [15:0] vb,
                           input logic [4:0] psr_in, output logic legal, output logic wr,
                           output logic [7:0] op, output logic [15:0] bval,
                           output logic [15:0] wdata, output logic [4:0] psr_out);
    logic [3:0]  hi, ext;
    logic        upd;
    logic [20:0] res;
    hi = ins[15:12]; ext = ins[7:4];
    legal = 1'b1; wr = 1'b1; upd = 1'b1; op = {hi, ext}; bval = vb;
    case (hi)
      4'h0: if (ext == 4'h0 || ext == 4'hA || (ext >= 4'hC && ext <= 4'hE)) begin
              wr = 1'b0; upd = 1'b0;
            end else if (ext == 4'hB || ext == 4'hF) wr = 1'b0;
      4'h5, 4'h7: bval = {{8{ins[7]}}, ins[7:0]};
      4'h6: bval = {8'h00, ins[7:0]};
      4'h9: begin op = 8'h09; bval = {{8{ins[7]}}, ins[7:0]}; end
      4'hB: begin op = 8'h0B; bval = {{8{ins[7]}}, ins[7:0]}; wr = 1'b0; end
      4'h8: if (ext <= 4'h1) begin op = 8'h80; bval = {12'h000, ins[3:0]}; end
            else if (ext == 4'h4) op = 8'h84;
            else legal = 1'b0;
      default: legal = 1'b0;
    endcase
    if (!legal) begin wr = 1'b0; upd = 1'b0; end
    res = alu_f(op, va, bval, psr_in[3]);
    wdata = res[15:0];
    psr_out = upd ? res[20:16] : psr_in;
  endtask

  typedef struct {
    logic [15:0] ins, va, vb;
    logic [7:0]  op;
    logic [15:0] b;
    logic        cin, we;
    logic [15:0] wdata;
    logic [4:0]  psr, pmask;
  } vec_t;

  vec_t tbl [10];
  logic [15:0] mreg [16];
  logic [4:0]  mpsr;

  initial begin
    int unsigned cnt0;
    reset = 1'b1; instr_valid = 1'b0; instr = '0;

    tbl[0] = '{16'h0152, 16'h7FFF, 16'h0001, 8'h05, 16'h0001, 1'b0, 1'b1, 16'h8000, 5'b00100, 5'h1F};
    tbl[1] = '{16'h53FF, 16'h0001, 16'h0000, 8'h5F, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 5'b10000, 5'b10000};
    tbl[2] = '{16'hB405, 16'h0003, 16'h1234, 8'h0B, 16'h0005, 1'b1, 1'b0, 16'h0000, 5'b00011, 5'h1F};
    tbl[3] = '{16'h8513, 16'h0011, 16'h5555, 8'h80, 16'h0003, 1'b0, 1'b1, 16'h0088, 5'b00000, 5'h1F};
    tbl[4] = '{16'h0162, 16'hFFFF, 16'h0001, 8'h06, 16'h0001, 1'b0, 1'b1, 16'h0000, 5'b11000, 5'h1F};
    tbl[5] = '{16'h06A7, 16'h2222, 16'h1234, 8'h0A, 16'h1234, 1'b1, 1'b0, 16'h0000, 5'b11000, 5'h1F};
    tbl[6] = '{16'h0677, 16'h0000, 16'h0000, 8'h07, 16'h0000, 1'b1, 1'b1, 16'h0001, 5'b00000, 5'h1F};
    tbl[7] = '{16'h9A01, 16'h0000, 16'h4444, 8'h09, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 5'b01000, 5'h1F};
    tbl[8] = '{16'h6B80, 16'h0001, 16'h0000, 8'h68, 16'h0080, 1'b1, 1'b1, 16'h0081, 5'b00000, 5'h1F};
    tbl[9] = '{16'h8C45, 16'h0003, 16'h0002, 8'h84, 16'h0002, 1'b0, 1'b1, 16'h000C, 5'b00000, 5'h1F};

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_psr", 32'(psr), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_ab", {alu_a, alu_b}, 32'd0);
    chk("rst_cin", 32'(alu_cin), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Reset asserted during EXEC of an ADD discards it.
    poke(4'd1, 16'hFFFF); poke(4'd2, 16'h0001);
    do_instr(16'h0162);
    chk("pre_abort_psr", 32'(o_psr), 32'(5'b11000));
    poke(4'd1, 16'h7FFF);
    @(negedge clk);
    instr = 16'h0152; instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_exec_busy", 32'(busy), 32'd1);
    cnt0 = we_cnt;
    reset = 1'b1;
    #1;
    chk("abort_ready_async", 32'(instr_ready), 32'd1);
    @(negedge clk);
    chk("abort_we", 32'(rf_we), 32'd0);
    chk("abort_psr", 32'(psr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(instr_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_write", we_cnt, cnt0);
    chk("abort_r1_kept", 32'(rf[1]), 32'h7FFF);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      poke(tbl[i].ins[3:0], tbl[i].vb);
      poke(tbl[i].ins[11:8], tbl[i].va);
      do_instr(tbl[i].ins);
      chk("vec_opcode", 32'(o_op), 32'(tbl[i].op));
      chk("vec_a", 32'(o_a), 32'(tbl[i].va));
      chk("vec_b", 32'(o_b), 32'(tbl[i].b));
      chk("vec_cin", 32'(o_cin), 32'(tbl[i].cin));
      chk("vec_we", 32'(o_we), 32'(tbl[i].we));
      chk("vec_we_early", 32'(o_early), 32'd0);
      chk("vec_busy_mid", {31'd0, o_busy}, 32'd1);
      chk("vec_ready_mid", 32'(o_rdy_mid), 32'd0);
      chk("vec_rf", 32'(rf[tbl[i].ins[11:8]]), 32'(tbl[i].we ? tbl[i].wdata : tbl[i].va));
      chk("vec_psr", 32'(o_psr & tbl[i].pmask), 32'(tbl[i].psr & tbl[i].pmask));
      chk("vec_ready_after", 32'(o_rdy), 32'd1);
      if (tbl[i].we) chk("vec_waddr", 32'(o_waddr), 32'(tbl[i].ins[11:8]));
    end

    // Randomized instructions against the reference model.
    reset_pulse();
    for (int r = 0; r < 16; r++) begin
      mreg[r] = 16'($urandom);
      poke(4'(r), mreg[r]);
    end
    mpsr = '0;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] rv;
      logic [3:0]  hi, rd;
      logic [15:0] ins, eb, ewd;
      logic [7:0]  eop;
      logic [4:0]  epsr;
      logic        legal, wr;
      rv = $urandom;
      case ($urandom_range(0, 8))
        0: hi = 4'h0; 1: hi = 4'h5; 2: hi = 4'h6; 3: hi = 4'h7;
        4: hi = 4'h8; 5: hi = 4'h9; 6: hi = 4'hB;
        default: hi = rv[31:28];
      endcase
      ins = {hi, rv[11:0]};
      if (hi == 4'h8 && rv[12]) ins[7:4] = rv[13] ? 4'h4 : {3'b000, rv[14]};
      rd = ins[11:8];
      ref_model(ins, mreg[rd], mreg[ins[3:0]], mpsr, legal, wr, eop, eb, ewd, epsr);
      if (TRAP && !legal) continue;
      do_instr(ins);
      chk("rnd_we", 32'(o_we), 32'(wr));
      chk("rnd_rf", 32'(rf[rd]), 32'(wr ? ewd : mreg[rd]));
      chk("rnd_psr", 32'(o_psr), 32'(epsr));
      chk("rnd_a", 32'(o_a), 32'(mreg[rd]));
      chk("rnd_cin", 32'(o_cin), 32'(mpsr[3]));
      if (legal) begin
        chk("rnd_opcode", 32'(o_op), 32'(eop));
        chk("rnd_b", 32'(o_b), 32'(eb));
      end
      if (wr) mreg[rd] = ewd;
      mpsr = epsr;
    end

    // Illegal instructions, after a known PSR value.
    poke(4'd1, 16'hFFFF); poke(4'd2, 16'h0001); poke(4'd0, 16'hABCD);
    do_instr(16'h0162);
    chk("ill_pre_psr", 32'(o_psr), 32'(5'b11000));
    if (TRAP) begin
      cnt0 = we_cnt;
      do_instr(16'hF000);
      chk("trap_illegal", 32'(o_ill), 32'd1);
      chk("trap_ready", 32'(o_rdy), 32'd0);
      chk("trap_psr", 32'(o_psr), 32'(5'b11000));
      @(negedge clk);
      instr = 16'h0152; instr_valid = 1'b1;
      repeat (5) @(negedge clk);
      instr_valid = 1'b0;
      chk("trap_still_halted", 32'({illegal, instr_ready, busy}), 32'(3'b101));
      chk("trap_no_write", we_cnt, cnt0);
      reset_pulse();
      chk("trap_cleared", 32'({illegal, instr_ready}), 32'(2'b01));
    end else begin
      do_instr(16'hF000);
      chk("ill_we", 32'(o_we), 32'd0);
      chk("ill_psr", 32'(o_psr), 32'(5'b11000));
      chk("ill_flag", 32'(o_ill), 32'd0);
      chk("ill_ready", 32'(o_rdy), 32'd1);
      chk("ill_r0", 32'(rf[0]), 32'hABCD);
      do_instr(16'h8020);
      chk("ill_shift_we", 32'(o_we), 32'd0);
      chk("ill_shift_psr", 32'(o_psr), 32'(5'b11000));
      chk("ill_shift_r0", 32'(rf[0]), 32'hABCD);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
